muldiv_hilo_ctrl: RTL and testbench

MULDIV_HILO_CTRL -- requirements
Module: muldiv_hilo_ctrl

---
 rtl/muldiv_hilo_ctrl_if.sv | 24 ++
 rtl/muldiv_hilo_ctrl.sv | 213 +++++++++++++++++++++
 tb/tb_muldiv_hilo_ctrl.sv | 283 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/muldiv_hilo_ctrl_if.sv
// Request/response bundle between the pipeline and the HI/LO multiply-divide unit.
interface muldiv_hilo_ctrl_if;
  logic        start;
  logic [2:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        flush;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  // Pipeline side: issues requests, observes stall/result.
  modport master (
    output start, op, a, b, flush,
    input  busy, done, hi, lo
  );

  // Unit side: accepts requests, owns HI/LO.
  modport slave (
    input  start, op, a, b, flush,
    output busy, done, hi, lo
  );
endinterface

// File: rtl/muldiv_hilo_ctrl.sv
// HI/LO multiply/divide controller.
// Multiply completes after a fixed MUL_LAT cycles; divide is a 32-step
// restoring divider on operand magnitudes with sign fix-up at the end.
// MTHI/MTLO write HI/LO directly without leaving IDLE.
module muldiv_hilo_ctrl #(
  parameter int MUL_LAT = 2
) (
  input  logic clk,
  input  logic rst,
  muldiv_hilo_ctrl_if.slave bus
);

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;

  localparam logic [4:0] MUL_LAST = 5'(MUL_LAT - 1);
  localparam logic [4:0] DIV_LAST = 5'd31;

  typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;

  state_t      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic        signed_q, signed_d;
  logic        div0_q, div0_d;
  logic        neg_quo_q, neg_quo_d;
  logic        neg_rem_q, neg_rem_d;
  logic [31:0] quo_q, quo_d;
  logic [31:0] rem_q, rem_d;
  logic [31:0] dvsr_q, dvsr_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic        done_q, done_d;

  // Multiply datapath: operands extended by one bit so MULT and MULTU
  // share one signed multiplier; only the low 64 bits are meaningful.
  logic signed [32:0] mul_a, mul_b;
  logic signed [65:0] mul_full;
  logic [63:0]        product;

  // One restoring-division step: shift in the next dividend bit, subtract
  // the divisor if it fits.
  logic [32:0] div_shifted;
  logic [32:0] div_diff;
  logic        div_fits;
  logic [31:0] step_rem;
  logic [31:0] step_quo;
  logic [31:0] final_quo;
  logic [31:0] final_rem;

  // Magnitudes and sign flags of the incoming operands for a new divide.
  logic        req_signed;
  logic [31:0] mag_a, mag_b;

  assign mul_a    = {signed_q & a_q[31], a_q};
  assign mul_b    = {signed_q & b_q[31], b_q};
  assign mul_full = mul_a * mul_b;
  assign product  = mul_full[63:0];

  assign div_shifted = {rem_q, quo_q[31]};
  assign div_diff    = div_shifted - {1'b0, dvsr_q};
  assign div_fits    = ~div_diff[32];
  assign step_rem    = div_fits ? div_diff[31:0] : div_shifted[31:0];
  assign step_quo    = {quo_q[30:0], div_fits};
  assign final_quo   = neg_quo_q ? (32'd0 - step_quo) : step_quo;
  assign final_rem   = neg_rem_q ? (32'd0 - step_rem) : step_rem;

  assign req_signed = (bus.op == OP_DIV);
  assign mag_a      = (req_signed && bus.a[31]) ? (32'd0 - bus.a) : bus.a;
  assign mag_b      = (req_signed && bus.b[31]) ? (32'd0 - bus.b) : bus.b;

  assign bus.busy = (state_q != IDLE);
  assign bus.done = done_q;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;

  // Next-state, operand capture and HI/LO update decisions.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    a_d       = a_q;
    b_d       = b_q;
    signed_d  = signed_q;
    div0_d    = div0_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    quo_d     = quo_q;
    rem_d     = rem_q;
    dvsr_d    = dvsr_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    done_d    = 1'b0;

    case (state_q)
      IDLE: begin
        // A flush in the same cycle cancels the request, including moves.
        if (bus.start && !bus.flush) begin
          case (bus.op)
            OP_MULT, OP_MULTU: begin
              state_d  = MUL;
              cnt_d    = 5'd0;
              a_d      = bus.a;
              b_d      = bus.b;
              signed_d = (bus.op == OP_MULT);
            end
            OP_DIV, OP_DIVU: begin
              state_d   = DIV;
              cnt_d     = 5'd0;
              a_d       = bus.a;
              b_d       = bus.b;
              signed_d  = req_signed;
              div0_d    = (bus.b == 32'd0);
              neg_quo_d = req_signed & (bus.a[31] ^ bus.b[31]);
              neg_rem_d = req_signed & bus.a[31];
              quo_d     = mag_a;
              dvsr_d    = mag_b;
              rem_d     = 32'd0;
            end
            OP_MTHI: begin
              hi_d   = bus.a;
              done_d = 1'b1;
            end
            OP_MTLO: begin
              lo_d   = bus.a;
              done_d = 1'b1;
            end
            default: ;
          endcase
        end
      end

      MUL: begin
        // Flush wins even on the last cycle: no write, no done.
        if (bus.flush) begin
          state_d = IDLE;
        end else if (cnt_q == MUL_LAST) begin
          hi_d    = product[63:32];
          lo_d    = product[31:0];
          done_d  = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 5'd1;
        end
      end

      DIV: begin
        if (bus.flush) begin
          state_d = IDLE;
        end else begin
          quo_d = step_quo;
          rem_d = step_rem;
          cnt_d = cnt_q + 5'd1;
          if (cnt_q == DIV_LAST) begin
            // Divide by zero still runs the full 32 steps, then reports
            // an all-ones quotient and the raw dividend as remainder.
            if (div0_q) begin
              lo_d = 32'hFFFF_FFFF;
              hi_d = a_q;
            end else begin
              lo_d = final_quo;
              hi_d = final_rem;
            end
            done_d  = 1'b1;
            state_d = IDLE;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // State register; reset overrides any request or completion.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= 5'd0;
      a_q       <= 32'd0;
      b_q       <= 32'd0;
      signed_q  <= 1'b0;
      div0_q    <= 1'b0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      quo_q     <= 32'd0;
      rem_q     <= 32'd0;
      dvsr_q    <= 32'd0;
      hi_q      <= 32'd0;
      lo_q      <= 32'd0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      a_q       <= a_d;
      b_q       <= b_d;
      signed_q  <= signed_d;
      div0_q    <= div0_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      quo_q     <= quo_d;
      rem_q     <= rem_d;
      dvsr_q    <= dvsr_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      done_q    <= done_d;
    end
  end

endmodule

// File: tb/tb_muldiv_hilo_ctrl.sv
// Directed bench for muldiv_hilo_ctrl (MUL_LAT = 2).
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_muldiv_hilo_ctrl;

  localparam int LAT = 2;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  muldiv_hilo_ctrl_if bus ();

  muldiv_hilo_ctrl #(.MUL_LAT(LAT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Present a request for one cycle, then scramble the operands so any
  // dependence on live inputs after acceptance shows up in the result.
  task automatic issue(input logic [2:0] o, input logic [31:0] av, input logic [31:0] bv);
    bus.start = 1'b1;
    bus.op    = o;
    bus.a     = av;
    bus.b     = bv;
    @(negedge clk);
    bus.start = 1'b0;
    bus.a     = $urandom;
    bus.b     = $urandom;
  endtask

  // Count remaining busy cycles (current cycle included), bounded.
  task automatic wait_idle(output int n);
    n = 0;
    while (bus.busy && n < 200) begin
      n++;
      @(negedge clk);
    end
  endtask

  // Run an operation to completion and check latency, done pulse and result.
  task automatic run_op(input string name, input logic [2:0] o,
                        input logic [31:0] av, input logic [31:0] bv,
                        input int exp_busy, input logic [31:0] exp_hi,
                        input logic [31:0] exp_lo);
    int n;
    issue(o, av, bv);
    wait_idle(n);
    $display("txn %s a=%08h b=%08h busy=%0d hi=%08h lo=%08h done=%0b",
             name, av, bv, n, bus.hi, bus.lo, bus.done);
    checks++;
    if (n !== exp_busy) begin
      failures++;
      $display("FAIL %s_busy_cycles got=%0d exp=%0d", name, n, exp_busy);
    end
    checks++;
    if (bus.done !== 1'b1) begin
      failures++;
      $display("FAIL %s_done got=%0b exp=1", name, bus.done);
    end
    checks++;
    if (bus.hi !== exp_hi) begin
      failures++;
      $display("FAIL %s_hi got=%08h exp=%08h", name, bus.hi, exp_hi);
    end
    checks++;
    if (bus.lo !== exp_lo) begin
      failures++;
      $display("FAIL %s_lo got=%08h exp=%08h", name, bus.lo, exp_lo);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    $display("txn RESET busy=%0b done=%0b hi=%08h lo=%08h", bus.busy, bus.done, bus.hi, bus.lo);
    checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      failures++;
      $display("FAIL reset_ctrl got busy=%0b done=%0b exp=0/0", bus.busy, bus.done);
    end
    checks++;
    if (bus.hi !== 32'd0 || bus.lo !== 32'd0) begin
      failures++;
      $display("FAIL reset_hilo got=%08h_%08h exp=0_0", bus.hi, bus.lo);
    end
  endtask

  task automatic test_move();
    checks++;
    if (bus.busy !== 1'b0) begin
      failures++;
      $display("FAIL mthi_busy_before got=%0b exp=0", bus.busy);
    end
    run_op("MTHI", 3'd4, 32'h1234_5678, 32'd0, 0, 32'h1234_5678, 32'd0);
    // Back-to-back: MTLO issued in the done cycle of MTHI.
    run_op("MTLO", 3'd5, 32'h0BAD_F00D, 32'd0, 0, 32'h1234_5678, 32'h0BAD_F00D);
    checks++;
    @(negedge clk);
    if (bus.done !== 1'b0) begin
      failures++;
      $display("FAIL move_done_pulse got=%0b exp=0", bus.done);
    end
  endtask

  task automatic test_mult();
    run_op("MULT", 3'd0, 32'hFFFF_FFFE, 32'd3, LAT, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
    // Back-to-back MULTU in the done cycle of MULT.
    run_op("MULTU", 3'd1, 32'hFFFF_FFFE, 32'd3, LAT, 32'h0000_0002, 32'hFFFF_FFFA);
    run_op("MULT_big", 3'd0, 32'h8000_0000, 32'h8000_0000, LAT, 32'h4000_0000, 32'h0000_0000);
    @(negedge clk);
    checks++;
    if (bus.done !== 1'b0) begin
      failures++;
      $display("FAIL mult_done_pulse got=%0b exp=0", bus.done);
    end
  endtask

  task automatic test_div();
    run_op("DIV", 3'd2, 32'hFFFF_FFF9, 32'd2, 32, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_op("DIVU0", 3'd3, 32'd7, 32'd0, 32, 32'h0000_0007, 32'hFFFF_FFFF);
    run_op("DIVU", 3'd3, 32'd100, 32'd7, 32, 32'd2, 32'd14);
    run_op("DIV0neg", 3'd2, 32'hFFFF_FFF0, 32'd0, 32, 32'hFFFF_FFF0, 32'hFFFF_FFFF);
    run_op("DIV_pos_neg", 3'd2, 32'd7, 32'hFFFF_FFFE, 32, 32'd1, 32'hFFFF_FFFD);
  endtask

  // DIV of most-negative by -1, with an MTLO request presented while busy.
  task automatic test_ignore_busy();
    int n;
    issue(3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
    bus.start = 1'b1;
    bus.op    = 3'd5;
    bus.a     = 32'hDEAD_BEEF;
    @(negedge clk);
    bus.start = 1'b0;
    checks++;
    if (bus.lo === 32'hDEAD_BEEF) begin
      failures++;
      $display("FAIL ignore_mtlo got lo=%08h exp=unchanged", bus.lo);
    end
    wait_idle(n);
    n = n + 1;
    $display("txn DIV_ovf_with_mtlo busy=%0d hi=%08h lo=%08h", n, bus.hi, bus.lo);
    checks++;
    if (n !== 32 || bus.done !== 1'b1) begin
      failures++;
      $display("FAIL div_ovf_timing got busy=%0d done=%0b exp=32/1", n, bus.done);
    end
    checks++;
    if (bus.hi !== 32'h0 || bus.lo !== 32'h8000_0000) begin
      failures++;
      $display("FAIL div_ovf_result got=%08h_%08h exp=00000000_80000000", bus.hi, bus.lo);
    end
  endtask

  task automatic test_flush();
    logic [31:0] hold_hi;
    logic [31:0] hold_lo;
    run_op("MTHI", 3'd4, 32'h1111_1111, 32'd0, 0, 32'h1111_1111, bus.lo);
    run_op("MTLO", 3'd5, 32'h1111_1111, 32'd0, 0, 32'h1111_1111, 32'h1111_1111);
    // Flush on busy cycle 10 of a DIVU.
    issue(3'd3, 32'd100, 32'd3);
    repeat (9) @(negedge clk);
    bus.flush = 1'b1;
    @(negedge clk);
    bus.flush = 1'b0;
    $display("txn DIVU_flush10 busy=%0b done=%0b hi=%08h lo=%08h", bus.busy, bus.done, bus.hi, bus.lo);
    checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      failures++;
      $display("FAIL flush_div_ctrl got busy=%0b done=%0b exp=0/0", bus.busy, bus.done);
    end
    checks++;
    if (bus.hi !== 32'h1111_1111 || bus.lo !== 32'h1111_1111) begin
      failures++;
      $display("FAIL flush_div_hilo got=%08h_%08h exp=11111111_11111111", bus.hi, bus.lo);
    end
    // Accepted in the very next cycle after the abort.
    run_op("MULTU_after_flush", 3'd1, 32'd5, 32'd6, LAT, 32'd0, 32'd30);

    // Flush in the last MUL busy cycle wins.
    hold_hi = bus.hi;
    hold_lo = bus.lo;
    issue(3'd1, 32'd9, 32'd9);
    @(negedge clk);
    bus.flush = 1'b1;
    @(negedge clk);
    bus.flush = 1'b0;
    $display("txn MULTU_flush_last busy=%0b done=%0b lo=%08h", bus.busy, bus.done, bus.lo);
    checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.lo !== hold_lo || bus.hi !== hold_hi) begin
      failures++;
      $display("FAIL flush_mul_last got busy=%0b done=%0b lo=%08h exp=0/0/%08h", bus.busy, bus.done, bus.lo, hold_lo);
    end

    // Flush in the last DIV busy cycle wins.
    issue(3'd3, 32'd50, 32'd5);
    repeat (31) @(negedge clk);
    bus.flush = 1'b1;
    @(negedge clk);
    bus.flush = 1'b0;
    $display("txn DIVU_flush_last busy=%0b done=%0b lo=%08h", bus.busy, bus.done, bus.lo);
    checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.lo !== hold_lo || bus.hi !== hold_hi) begin
      failures++;
      $display("FAIL flush_div_last got busy=%0b done=%0b lo=%08h exp=0/0/%08h", bus.busy, bus.done, bus.lo, hold_lo);
    end

    // Flush together with start in IDLE drops the request.
    bus.flush = 1'b1;
    issue(3'd4, 32'hCAFE_CAFE, 32'd0);
    bus.flush = 1'b1;
    issue(3'd2, 32'd10, 32'd2);
    bus.flush = 1'b0;
    $display("txn flush_with_start busy=%0b done=%0b hi=%08h", bus.busy, bus.done, bus.hi);
    checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.hi !== hold_hi) begin
      failures++;
      $display("FAIL flush_start_idle got busy=%0b done=%0b hi=%08h exp=0/0/%08h", bus.busy, bus.done, bus.hi, hold_hi);
    end

    // Reserved op code is a no-op.
    issue(3'd6, 32'h5555_5555, 32'd1);
    checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.hi !== hold_hi || bus.lo !== hold_lo) begin
      failures++;
      $display("FAIL noop_op got busy=%0b done=%0b hi=%08h lo=%08h", bus.busy, bus.done, bus.hi, bus.lo);
    end
  endtask

  task automatic test_reset_mid_div();
    int late;
    issue(3'd2, 32'd1000, 32'd3);
    repeat (19) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    $display("txn DIV_reset20 busy=%0b done=%0b hi=%08h lo=%08h", bus.busy, bus.done, bus.hi, bus.lo);
    checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.hi !== 32'd0 || bus.lo !== 32'd0) begin
      failures++;
      $display("FAIL reset_mid_div got busy=%0b done=%0b hi=%08h lo=%08h exp=0/0/0/0",
               bus.busy, bus.done, bus.hi, bus.lo);
    end
    late = 0;
    repeat (20) begin
      @(negedge clk);
      if (bus.done !== 1'b0 || bus.hi !== 32'd0 || bus.lo !== 32'd0 || bus.busy !== 1'b0) late++;
    end
    checks++;
    if (late !== 0) begin
      failures++;
      $display("FAIL reset_late_write got=%0d bad cycles exp=0", late);
    end
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    rst       = 1'b1;
    bus.start = 1'b0;
    bus.op    = 3'd0;
    bus.a     = 32'd0;
    bus.b     = 32'd0;
    bus.flush = 1'b0;
    @(negedge clk);
    test_reset();
    test_move();
    test_mult();
    test_div();
    test_ignore_busy();
    test_flush();
    test_reset_mid_div();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
